// File: rtl/cache_arb_pkg.sv
// -----------------------------------------------------------------------------
// cache_arb_pkg
//   Shared types and constants for the two-port cache request arbiter.
//   arb_state_t : FSM states of the arbiter.
//   arb_port_t  : requesting port identifiers (I = fetch, D = load/store).
//   WAIT_MAX    : saturation value of the busy-cycle counter.
// -----------------------------------------------------------------------------
package cache_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } arb_port_t;

  localparam logic [31:0] WAIT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/cache_arb_pick.sv
// -----------------------------------------------------------------------------
// cache_arb_pick
//   Combinational winner selection between the I and D ports.
//   Build option: CACHE_ARB_RR_EN
//     defined   -> round-robin; on a conflict the port not named by ptr wins.
//     undefined -> fixed priority, D over I; ptr is ignored.
// Ports:
//   i_req, d_req : masked request levels
//   ptr          : last-granted port (round-robin history)
//   valid        : at least one request is pending
//   winner       : port to grant when valid
// -----------------------------------------------------------------------------
module cache_arb_pick
  import cache_arb_pkg::*;
(
  input  logic      i_req,
  input  logic      d_req,
  input  arb_port_t ptr,
  output logic      valid,
  output arb_port_t winner
);

  assign valid = i_req | d_req;

`ifdef CACHE_ARB_RR_EN
  always_comb begin
    winner = PORT_I;
    if (i_req && d_req) begin
      winner = (ptr == PORT_D) ? PORT_I : PORT_D;
    end else if (d_req) begin
      winner = PORT_D;
    end
  end
`else
  // History is irrelevant under fixed priority.
  logic unused_ptr;
  assign unused_ptr = ptr;

  assign winner = d_req ? PORT_D : PORT_I;
`endif

endmodule

// File: rtl/cache_arbiter.sv
// -----------------------------------------------------------------------------
// cache_arbiter
//   Two-port front end for the shared cache. Grants one of the instruction
//   fetch (I) or load/store (D) requests, presents it to the cache from
//   latched registers until c_hit, then returns read data and a one-cycle
//   done pulse to the owning port.
//   Build option: CACHE_ARB_RR_EN selects round-robin instead of D-priority
//   (handled entirely inside cache_arb_pick).
// Ports:
//   clk, reset_n                 : clock, async active-low reset
//   en                           : global enable; freezes all state when 0
//   i_req/i_addr/i_rdata/i_done  : instruction port (read only)
//   d_req/d_write/d_addr/d_wdata : data port request
//   d_rdata/d_done               : data port response
//   c_ready/c_write_en/c_addr/c_data : request side of the cache
//   c_hit/c_out                  : cache completion and read data
//   busy, owner                  : transaction outstanding / granted port
//   wait_cycles                  : saturating count of cycles spent busy
// -----------------------------------------------------------------------------
module cache_arbiter
  import cache_arb_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        c_ready,
  output logic        c_write_en,
  output logic [31:0] c_addr,
  output logic [31:0] c_data,
  input  logic        c_hit,
  input  logic [31:0] c_out,
  output logic        busy,
  output logic        owner,
  output logic [31:0] wait_cycles
);

  arb_state_t  state_q, state_d;
  arb_port_t   owner_q;
  arb_port_t   pick_winner;
  logic        pick_valid;
  logic        grant, complete;
  logic        i_done_q, d_done_q;
  logic        lat_write;
  logic [31:0] lat_addr, lat_data;

  // The done register doubles as the one-cycle request mask: a port still
  // showing req in its done cycle is a stale request and must not win.
  cache_arb_pick u_pick (
    .i_req  (i_req & ~i_done_q),
    .d_req  (d_req & ~d_done_q),
    .ptr    (owner_q),           // owner is exactly the last-granted port
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    grant    = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_d = ARB_BUSY;
          grant   = 1'b1;
        end
      end
      ARB_BUSY: begin
        if (c_hit) begin
          state_d  = ARB_IDLE;
          complete = 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ARB_IDLE;
      owner_q     <= PORT_I;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      lat_write   <= 1'b0;
      lat_addr    <= '0;
      lat_data    <= '0;
      i_rdata     <= '0;
      d_rdata     <= '0;
      wait_cycles <= '0;
    end else if (en) begin
      // NOTE: state is updated with non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state_q  <= state_d;
      i_done_q <= complete && (owner_q == PORT_I);
      d_done_q <= complete && (owner_q == PORT_D);

      if (grant) begin
        owner_q   <= pick_winner;
        lat_write <= (pick_winner == PORT_D) && d_write;
        lat_addr  <= (pick_winner == PORT_D) ? d_addr : i_addr;
        lat_data  <= (pick_winner == PORT_D) ? d_wdata : '0;
      end

      if (state_q == ARB_BUSY && wait_cycles != WAIT_MAX) begin
        wait_cycles <= wait_cycles + 32'd1;
      end

      if (complete && !lat_write) begin
        if (owner_q == PORT_I) i_rdata <= c_out;
        else                   d_rdata <= c_out;
      end
    end
  end

  // c_ready stays up while frozen by en=0 so the cache keeps its request.
  assign c_ready    = (state_q == ARB_BUSY);
  assign c_write_en = c_ready & lat_write;
  assign c_addr     = lat_addr;
  assign c_data     = lat_data;
  assign busy       = c_ready;
  assign owner      = owner_q;
  assign i_done     = i_done_q & en;
  assign d_done     = d_done_q & en;

endmodule

// File: tb/tb_cache_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cache_arbiter
//   Self-checking bench for cache_arbiter. Inputs change 1 time unit after the
//   rising edge; outputs are compared on the falling edge. Completions are
//   matched against a queue of expected {port, rdata} records.
// -----------------------------------------------------------------------------
module tb_cache_arbiter;

  logic        clk, reset_n, en;
  logic        i_req, d_req, d_write, c_hit;
  logic [31:0] i_addr, d_addr, d_wdata, c_out;
  logic [31:0] i_rdata, d_rdata, c_addr, c_data, wait_cycles;
  logic        i_done, d_done, c_ready, c_write_en, busy, owner;

  cache_arbiter dut (
    .clk(clk), .reset_n(reset_n), .en(en),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .c_ready(c_ready), .c_write_en(c_write_en), .c_addr(c_addr), .c_data(c_data),
    .c_hit(c_hit), .c_out(c_out),
    .busy(busy), .owner(owner), .wait_cycles(wait_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        port;
    logic [31:0] rdata;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic        port;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] cout;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t vecs[6];

  logic [31:0] exp_wait, exp_i_rdata, exp_d_rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values();
    check("rst_c_ready", c_ready, 0);
    check("rst_c_write_en", c_write_en, 0);
    check("rst_c_addr", c_addr, 0);
    check("rst_c_data", c_data, 0);
    check("rst_i_done", i_done, 0);
    check("rst_d_done", d_done, 0);
    check("rst_i_rdata", i_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_busy", busy, 0);
    check("rst_owner", owner, 0);
    check("rst_wait_cycles", wait_cycles, 0);
  endtask

  // Called just after the sampling edge; returns just after the hit edge
  // (start of the done cycle) with c_hit cleared.
  task automatic run_busy(input logic port, input logic write, input logic [31:0] addr,
                          input logic [31:0] data, input int delay,
                          input logic [31:0] cout, input logic [31:0] exp_rd);
    sb_t e;
    for (int k = 1; k <= delay; k++) begin
      c_hit = (k == delay);
      c_out = (k == delay) ? cout : ~cout;
      @(negedge clk);
      check("busy_c_ready", c_ready, 1);
      check("busy_owner", owner, port);
      check("busy_c_addr", c_addr, addr);
      check("busy_c_write_en", c_write_en, write);
      if (write) check("busy_c_data", c_data, data);
      check("busy_wait_cycles", wait_cycles, exp_wait);
      if (k == delay) begin
        e.port  = port;
        e.rdata = write ? exp_d_rdata : exp_rd;
        sb_q.push_back(e);
        if (!write) begin
          if (port) exp_d_rdata = exp_rd;
          else      exp_i_rdata = exp_rd;
        end
      end
      if (exp_wait != 32'hFFFF_FFFF) exp_wait++;
      tick();
    end
    c_hit = 1'b0;
  endtask

  // Called in the done cycle after requests were updated.
  task automatic finish_done(input logic port);
    @(negedge clk);
    check(port ? "d_done_pulse" : "i_done_pulse", port ? d_done : i_done, 1);
    check("done_cycle_busy", busy, 0);
    check("done_cycle_wait", wait_cycles, exp_wait);
    tick();
  endtask

  task automatic txn(input vec_t v);
    if (v.port) begin
      d_req = 1'b1; d_write = v.write; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      i_req = 1'b1; i_addr = v.addr;
    end
    @(negedge clk);
    check("idle_c_ready", c_ready, 0);
    tick();
    run_busy(v.port, v.write, v.addr, v.wdata, v.delay, v.cout, v.exp_rdata);
    i_req = 1'b0;
    d_req = 1'b0;
    finish_done(v.port);
  endtask

  // Completion monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    sb_t e;
    if (i_done || d_done) begin
      check("done_onehot", {31'b0, i_done & d_done}, 0);
      if (sb_q.size() == 0) begin
        check("done_spurious", {30'b0, d_done, i_done}, 0);
      end else begin
        e = sb_q.pop_front();
        check("done_port", d_done, e.port);
        check("done_rdata", e.port ? d_rdata : i_rdata, e.rdata);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic first, second;
    vecs[0] = '{port:1'b0, write:1'b0, addr:32'h0000_0040, wdata:32'h0, delay:1,
                cout:32'h1234_5678, exp_rdata:32'h1234_5678};
    vecs[1] = '{port:1'b1, write:1'b1, addr:32'h0000_0100, wdata:32'hDEAD_BEEF, delay:5,
                cout:32'hBAD0_BAD0, exp_rdata:32'h0};
    vecs[2] = '{port:1'b1, write:1'b0, addr:32'h0000_0200, wdata:32'h0, delay:2,
                cout:32'hCAFE_F00D, exp_rdata:32'hCAFE_F00D};
    vecs[3] = '{port:1'b0, write:1'b0, addr:32'h0000_0044, wdata:32'h0, delay:3,
                cout:32'h0BAD_F00D, exp_rdata:32'h0BAD_F00D};
    vecs[4] = '{port:1'b1, write:1'b1, addr:32'h0000_0104, wdata:32'h1122_3344, delay:1,
                cout:32'h5A5A_5A5A, exp_rdata:32'h0};
    vecs[5] = '{port:1'b1, write:1'b0, addr:32'h0000_0300, wdata:32'h0, delay:1,
                cout:32'hA5A5_A5A5, exp_rdata:32'hA5A5_A5A5};

    reset_n = 1'b0; en = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
    c_hit = 1'b0; c_out = '0;
    exp_wait = '0; exp_i_rdata = '0; exp_d_rdata = '0;

    #3 check_reset_values();
    tick();
    reset_n = 1'b1;
    tick();

    // Table of single transactions.
    for (int i = 0; i < 6; i++) txn(vecs[i]);
    check("wait_after_table", wait_cycles, 32'd13);

    // Stale request mask: D keeps req in its done cycle while I asks.
    d_req = 1'b1; d_write = 1'b0; d_addr = 32'h500;
    tick();
    run_busy(1'b1, 1'b0, 32'h500, 32'h0, 1, 32'h5555_0001, 32'h5555_0001);
    i_req = 1'b1; i_addr = 32'h600;
    finish_done(1'b1);
    run_busy(1'b0, 1'b0, 32'h600, 32'h0, 2, 32'h6666_0002, 32'h6666_0002);
    i_req = 1'b0;
    finish_done(1'b0);
    run_busy(1'b1, 1'b0, 32'h500, 32'h0, 1, 32'h5555_0003, 32'h5555_0003);
    d_req = 1'b0;
    finish_done(1'b1);

    // Enable hold: hit presented while en=0 must be ignored.
    d_req = 1'b1; d_write = 1'b1; d_addr = 32'h700; d_wdata = 32'h7777_7777;
    tick();
    c_hit = 1'b1; c_out = 32'h0; en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("hold_c_ready", c_ready, 1);
      check("hold_busy", busy, 1);
      check("hold_d_done", d_done, 0);
      check("hold_wait", wait_cycles, exp_wait);
      tick();
    end
    en = 1'b1;
    sb_q.push_back('{port:1'b1, rdata:exp_d_rdata});
    @(negedge clk);
    check("hold_resume_wait", wait_cycles, exp_wait);
    tick();
    exp_wait++;
    c_hit = 1'b0; d_req = 1'b0;
    finish_done(1'b1);
    check("hold_store_d_rdata", d_rdata, 32'h5555_0003);

    // Counter saturation.
    @(negedge clk);
    force dut.wait_cycles = 32'hFFFF_FFFD;
    #1 release dut.wait_cycles;
    exp_wait = 32'hFFFF_FFFD;
    check("wait_preset", wait_cycles, exp_wait);
    tick();
    txn('{port:1'b0, write:1'b0, addr:32'h800, wdata:32'h0, delay:4,
          cout:32'h8888_8888, exp_rdata:32'h8888_8888});
    check("wait_saturated", wait_cycles, 32'hFFFF_FFFF);

    // Reset in the middle of a transaction.
    i_req = 1'b1; i_addr = 32'h900;
    tick();
    @(negedge clk);
    check("pre_reset_busy", busy, 1);
    #2 reset_n = 1'b0;
    #1 check_reset_values();
    i_req = 1'b0;
    exp_wait = '0; exp_i_rdata = '0; exp_d_rdata = '0;
    tick();
    reset_n = 1'b1;
    c_hit = 1'b1;
    tick();
    c_hit = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    check("post_reset_busy", busy, 0);
    check("post_reset_wait", wait_cycles, 0);
    tick();

    // Simultaneous requests.
    i_req = 1'b1; i_addr = 32'hA00;
    d_req = 1'b1; d_write = 1'b0; d_addr = 32'hB00;
    tick();
    run_busy(1'b1, 1'b0, 32'hB00, 32'h0, 1, 32'hBBBB_0001, 32'hBBBB_0001);
    i_req = 1'b0; d_req = 1'b0;
    finish_done(1'b1);
    @(negedge clk);
    check("forgotten_i_idle", busy, 0);
    tick();
    i_req = 1'b1; d_req = 1'b1;
    tick();
`ifdef CACHE_ARB_RR_EN
    first = 1'b0;
`else
    first = 1'b1;
`endif
    second = ~first;
    run_busy(first, 1'b0, first ? 32'hB00 : 32'hA00, 32'h0, 1,
             32'hC0C0_0001, 32'hC0C0_0001);
    if (first) d_req = 1'b0; else i_req = 1'b0;
    finish_done(first);
    run_busy(second, 1'b0, second ? 32'hB00 : 32'hA00, 32'h0, 2,
             32'hC0C0_0002, 32'hC0C0_0002);
    i_req = 1'b0; d_req = 1'b0;
    finish_done(second);

    repeat (3) tick();
    check("scoreboard_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Two-port front end for the shared MIPS cache. It accepts word requests from the instruction-fetch port (I) and the load/store port (D), and grants one at a time. It presents the granted request to the cache's ready/write_en/addr/data interface and holds it until the cache reports hit. It then returns read data and a one-cycle done pulse to the owning port. It sits between the CPU pipeline and the `Cache` instance and owns the cache's request side.

## Interface
- No parameters. Cache geometry is taken from `cache.vh`. All data and address paths are 32 bits.
- `clk` in 1: the single clock. All state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `en` in 1: global enable, same meaning as the cache's `en`. While 0, all state and counters hold; done outputs are 0.
- `i_req` in 1: I-port request, level. Held until `i_done`.
- `i_addr` in 32: I-port byte address. Stable while `i_req`=1.
- `i_rdata` out 32: I-port read data register.
- `i_done` out 1: one-cycle I-port completion pulse.
- `d_req` in 1: D-port request, level. Held until `d_done`.
- `d_write` in 1: D-port store (1) / load (0). Stable while `d_req`=1.
- `d_addr`, `d_wdata` in 32: D-port address and store data. Stable while `d_req`=1.
- `d_rdata` out 32: D-port read data register. Updated on loads only.
- `d_done` out 1: one-cycle D-port completion pulse.
- `c_ready` out 1: cache request valid.
- `c_write_en` out 1: to the cache's `write_en`.
- `c_addr`, `c_data` out 32: to the cache's `addr` and `data`.
- `c_hit` in 1: cache access complete this cycle.
- `c_out` in 32: cache read data, valid when `c_hit`=1.
- `busy` out 1: 1 while a transaction is outstanding.
- `owner` out 1: granted port (0=I, 1=D). Meaningful only while `busy`=1.
- `wait_cycles` out 32: total cycles spent in BUSY, saturating at 0xFFFF_FFFF.

## Operation
- The FSM has two states, IDLE and BUSY.
- **IDLE:**
  - `c_ready`=0.
  - If either request is high, pick a winner (see Configuration).
  - Latch the winner's addr/wdata/write into internal registers; the I port is always a read.
  - Set `owner` and go to BUSY.
  - With no request, stay in IDLE.
- **BUSY:**
  - `c_ready`=1; the `c_*` outputs are driven from the latched registers only, never from the live port inputs.
  - On a cycle where `c_hit`=1:
    - Pulse the owner's done on the next cycle.
    - On a read, load `c_out` into the owner's rdata at that same edge.
    - Return to IDLE.
  - While `c_hit`=0, stay in BUSY and increment `wait_cycles` with saturation. The increment also happens on the hit cycle.
- **Request sampling:** requests are sampled only in IDLE.
  - A port dropping req before it is granted is a protocol violation.
  - Required behaviour for that violation: a request that was already granted still completes and pulses done; an ungranted one is simply forgotten.
- **Back-to-back:** after done, the finished port must drop req in the done cycle. The arbiter is in IDLE during the done cycle and re-arbitrates that same cycle.
  - The port that just finished must not be regranted from a stale req. Enforcement: for one cycle after its done, a port's req is masked.
- **Store data:** `d_rdata` is unchanged on stores.
- **Gating by `en`:** when `en`=0 in BUSY, `c_ready` stays 1 but the FSM and `wait_cycles` do not advance, and `c_hit` is ignored.

## Timing
- **Reset (async assert) values:** state=IDLE, `c_ready`=0, `c_write_en`=0, `c_addr`=0, `c_data`=0, `i_done`=`d_done`=0, `i_rdata`=`d_rdata`=0, `busy`=0, `owner`=0, `wait_cycles`=0, round-robin pointer=I, done masks clear.
- **Reset mid-transaction:** the transaction is dropped and no done is issued. The requester must reissue.
- **Latency:** req seen in IDLE at edge t. BUSY (`c_ready`=1) during cycle t+1. If `c_hit`=1 in cycle t+1, done is high during cycle t+2. Minimum latency is 2 cycles from the sampling edge; a miss adds the cache's fill cycles.
- **Throughput:** minimum one transaction per 2 cycles. There is one IDLE cycle between transactions.
- **Pulse width:** `i_done` and `d_done` are exactly one cycle wide and never high simultaneously.

## Configuration
- **`CACHE_ARB_RR_EN` defined:** round-robin arbitration.
  - A 1-bit pointer marks the last-granted port.
  - On a conflict, the other port wins.
  - The pointer updates on every grant.
- **`CACHE_ARB_RR_EN` undefined:** fixed priority, D over I.
  - The pointer register is not built.
  - I may starve under continuous D traffic; this is the accepted behaviour.

## Structure
- **Package `cache_arb_pkg`:**
  - `arb_state_t` enum {ARB_IDLE, ARB_BUSY}.
  - `arb_port_t` enum {PORT_I=0, PORT_D=1}.
  - `WAIT_MAX` constant.
- **Sub-module `cache_arb_pick`:** combinational winner selection.
  - Inputs: masked requests and the pointer.
  - Outputs: valid and the winning port.
  - Holds the `CACHE_ARB_RR_EN` ifdef, so the FSM is identical in both builds.

## Test plan
- **Single I read:** I read at 0x0000_0040 with the cache returning `c_hit` in the first BUSY cycle and `c_out`=0x1234_5678 -> `i_done` at t+2, `i_rdata`=0x1234_5678, `wait_cycles`=1.
- **Store with miss:** D store of 0xDEAD_BEEF to 0x0000_0100 with `c_hit` delayed 5 cycles -> `c_write_en`=1, `c_addr`=0x100 and `c_data`=0xDEADBEEF held steady for 5 cycles; `d_done` once; `d_rdata` unchanged.
- **Simultaneous requests:** I and D requests both asserted in the same IDLE cycle -> D granted first. With RR, the next conflict grants I; without RR, D is granted whenever both are pending.
- **Reset mid-transaction:** `reset_n` pulsed low while in BUSY -> all outputs return to reset values immediately and no done pulse follows.
- **Enable hold:** `en`=0 for 3 cycles during BUSY with `c_hit`=1 -> no completion and no count change until `en` returns to 1; then done follows.
- **Counter saturation:** `wait_cycles` forced near 0xFFFF_FFFE, then a 4-cycle miss -> the counter stops at 0xFFFF_FFFF.
